// File: rtl/game_pkg.sv
// Shared definitions for the game FSM <-> player executor instruction bus.
package game_pkg;

    localparam logic [3:0] OP_HPY = 4'd1;
    localparam logic [3:0] OP_DPY = 4'd2;
    localparam logic [3:0] OP_IDG = 4'd3;
    localparam logic [3:0] OP_SDG = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_SHP = 4'd6;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] arg;
        logic [3:0] pad;
    } instr_t;

    // Ops that are qualified by a startDmg rising edge and acknowledged.
    function automatic logic is_dmg_class(input logic [3:0] op);
        return (op == OP_HPY) || (op == OP_DPY) || (op == OP_IDG) ||
               (op == OP_SDG) || (op == OP_SHP);
    endfunction

endpackage

// File: rtl/player_mover.sv
// Player position registers with repeat-step divider and dodge-box clamping.
module player_mover
    import game_pkg::*;
#(
    parameter int X_MIN    = 220,
    parameter int X_MAX    = 420,
    parameter int Y_MIN    = 240,
    parameter int Y_MAX    = 400,
    parameter int X_START  = 320,
    parameter int Y_START  = 320,
    parameter int MOVE_DIV = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_dir,
    output logic [9:0] o_x,
    output logic [9:0] o_y
);

    localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             w_step;

    // A step lands on the first enabled cycle and then each time the divider wraps.
    assign w_step = i_en && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_x   <= 10'(X_START);
            r_y   <= 10'(Y_START);
        end else begin
            if (!i_en)
                r_cnt <= '0;
            else if (r_cnt == CNT_W'(MOVE_DIV - 1))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (w_step) begin
                case (i_dir)
                    DIR_UP:    if (r_y > 10'(Y_MIN)) r_y <= r_y - 1'b1;
                    DIR_LEFT:  if (r_x > 10'(X_MIN)) r_x <= r_x - 1'b1;
                    DIR_DOWN:  if (r_y < 10'(Y_MAX)) r_y <= r_y + 1'b1;
                    DIR_RIGHT: if (r_x < 10'(X_MAX)) r_x <= r_x + 1'b1;
                endcase
            end
        end
    end

    assign o_x = r_x;
    assign o_y = r_y;

endmodule

// File: rtl/player_executor.sv
// Decodes player instructions from the game FSM; owns HP, immunity and death state.
module player_executor
    import game_pkg::*;
#(
    parameter int MAX_HP       = 100,
    parameter int X_MIN        = 220,
    parameter int X_MAX        = 420,
    parameter int Y_MIN        = 240,
    parameter int Y_MAX        = 400,
    parameter int X_START      = 320,
    parameter int Y_START      = 320,
    parameter int MOVE_DIV     = 250000,
    parameter int INVUL_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] playerInstruction,
    input  logic        isMove,
    input  logic        startDmg,
    output logic [9:0]  playerX,
    output logic [9:0]  playerY,
    output logic [7:0]  playerHP,
    output logic        isDeath,
    output logic        invul,
    output logic        dmgAck
);

    localparam int TMR_W = $clog2(INVUL_CYCLES + 1);

    logic             r_start_q;
    logic             r_sticky;
    logic             r_death;
    logic             r_ack;
    logic [7:0]       r_hp;
    logic [TMR_W-1:0] r_timer;

    logic [3:0] w_op;
    logic [7:0] w_arg;
    logic [3:0] w_unused_pad;
    logic       w_edge;
    logic       w_invul;
    logic       w_dpy_hit;
    logic       w_move_en;
    logic [8:0] w_heal;
    logic [7:0] w_hp_next;

    assign {w_op, w_arg, w_unused_pad} = playerInstruction;
    assign w_edge    = startDmg && !r_start_q;
    assign w_invul   = r_sticky || (r_timer != '0);
    assign w_move_en = isMove && (w_op == OP_MOV) && !r_death;
    assign w_heal    = {1'b0, r_hp} + {1'b0, w_arg};

    always_comb begin
        w_hp_next = r_hp;
        w_dpy_hit = 1'b0;
        if (w_edge) begin
            case (w_op)
                OP_HPY: if (!r_death)
                    w_hp_next = (w_heal > 9'(MAX_HP)) ? 8'(MAX_HP) : w_heal[7:0];
                OP_DPY: if (!r_death && !w_invul && (w_arg != 8'd0)) begin
                    w_dpy_hit = 1'b1;
                    w_hp_next = (w_arg >= r_hp) ? 8'd0 : r_hp - w_arg;
                end
                OP_SHP: w_hp_next = (w_arg > 8'(MAX_HP)) ? 8'(MAX_HP) : w_arg;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_start_q <= 1'b0;
            r_sticky  <= 1'b0;
            r_death   <= 1'b0;
            r_ack     <= 1'b0;
            r_hp      <= 8'(MAX_HP);
            r_timer   <= '0;
        end else begin
            r_start_q <= startDmg;
            r_hp      <= w_hp_next;
            // While dead only SHP can move HP, so tracking HP==0 gives the sticky behaviour.
            r_death   <= (w_hp_next == 8'd0);
            r_ack     <= w_edge && is_dmg_class(w_op);

            if (w_dpy_hit)
                r_timer <= TMR_W'(INVUL_CYCLES);
            else if (r_timer != '0)
                r_timer <= r_timer - 1'b1;

            if (w_edge && (w_op == OP_IDG))
                r_sticky <= 1'b1;
            else if (w_edge && (w_op == OP_SDG))
                r_sticky <= 1'b0;
        end
    end

    player_mover #(
        .X_MIN    (X_MIN),
        .X_MAX    (X_MAX),
        .Y_MIN    (Y_MIN),
        .Y_MAX    (Y_MAX),
        .X_START  (X_START),
        .Y_START  (Y_START),
        .MOVE_DIV (MOVE_DIV)
    ) u_mover (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_move_en),
        .i_dir (w_arg[1:0]),
        .o_x   (playerX),
        .o_y   (playerY)
    );

    assign playerHP = r_hp;
    assign isDeath  = r_death;
    assign invul    = w_invul;
    assign dmgAck   = r_ack;

endmodule
